ddr_cmd_ctrl: RTL and testbench

- Upstream stage of the DDR1 memory array. Decodes registered DDR1 command pins and tracks per-bank open/closed state with tRCD/tRP timers.
- Holds the mode register and generates the row, column, bank and burst control signals the array consumes: ra, ca, ba, row_active, read_active, write_active, burst_stop, burst_len, burst_type.
- Runs on the single system clock; the array's double-edge data path is driven from these registered controls.

---
 rtl/ddr_pkg.sv | 45 ++++
 rtl/ddr_bank_fsm.sv | 90 +++++++++
 rtl/ddr_cmd_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_ddr_cmd_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared command encodings, FSM state types and mode-register defaults for the
// DDR1 command controller.
package ddr_pkg;

    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_BST = 4'b0110,
        CMD_NOP = 4'b0111
    } cmd_e;

    typedef enum logic [1:0] {
        B_IDLE        = 2'd0,
        B_ACTIVATING  = 2'd1,
        B_ACTIVE      = 2'd2,
        B_PRECHARGING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        BU_IDLE  = 2'd0,
        BU_BURST = 2'd1,
        BU_GAP   = 2'd2
    } burst_state_e;

    localparam logic [2:0] MR_BL_RST = 3'd1;
    localparam logic       MR_BT_RST = 1'b0;
    localparam logic [2:0] MR_CL_RST = 3'd2;

    // Burst length in beats for a mode-register BL code; 0 marks an unsupported code.
    function automatic logic [3:0] bl_beats(input logic [2:0] code);
        logic [3:0] beats;
        case (code)
            3'd1:    beats = 4'd2;
            3'd2:    beats = 4'd4;
            3'd3:    beats = 4'd8;
            default: beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ddr_bank_fsm.sv
// One bank's open/closed tracking: activate/precharge timing and the latched row.
module ddr_bank_fsm
    import ddr_pkg::*;
#(
    parameter int ROW_WIDTH = 14,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 act_i,
    input  logic                 pre_i,
    input  logic [ROW_WIDTH-1:0] row_i,
    output bank_state_e          state_o,
    output logic [ROW_WIDTH-1:0] ra_o,
    output logic                 row_active_o
);

    bank_state_e          state_q, state_d;
    logic [3:0]           tmr_q, tmr_d;
    logic [ROW_WIDTH-1:0] ra_q, ra_d;
    logic                 row_active_q, row_active_d;

    // Next-state logic; a timer of 0 means the current wait ends at this edge.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        ra_d         = ra_q;
        row_active_d = row_active_q;
        case (state_q)
            B_IDLE: begin
                if (act_i) begin
                    state_d = B_ACTIVATING;
                    tmr_d   = 4'(T_RCD - 1);
                    ra_d    = row_i;
                end else begin
                    state_d = B_IDLE;
                end
            end
            B_ACTIVATING: begin
                if (tmr_q == 4'd0) begin
                    state_d      = B_ACTIVE;
                    row_active_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            B_ACTIVE: begin
                if (pre_i) begin
                    state_d      = B_PRECHARGING;
                    tmr_d        = 4'(T_RP - 1);
                    row_active_d = 1'b0;
                end else begin
                    state_d = B_ACTIVE;
                end
            end
            B_PRECHARGING: begin
                if (tmr_q == 4'd0) begin
                    state_d = B_IDLE;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            default: begin
                state_d      = B_IDLE;
                row_active_d = 1'b0;
            end
        endcase
    end

    // Bank state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= B_IDLE;
            tmr_q        <= 4'd0;
            ra_q         <= '0;
            row_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            ra_q         <= ra_d;
            row_active_q <= row_active_d;
        end
    end

    assign state_o      = state_q;
    assign ra_o         = ra_q;
    assign row_active_o = row_active_q;

endmodule

// File: rtl/ddr_cmd_ctrl.sv
// DDR1 command decoder: checks command legality against bank, burst and
// block-window state, and drives the registered array controls.
module ddr_cmd_ctrl
    import ddr_pkg::*;
#(
    parameter int ROW_WIDTH = 14,
    parameter int COL_WIDTH = 10,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_MRD     = 2,
    parameter int T_RFC     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cke_i,
    input  logic                      cs_n_i,
    input  logic                      ras_n_i,
    input  logic                      cas_n_i,
    input  logic                      we_n_i,
    input  logic [ROW_WIDTH-1:0]      addr_i,
    input  logic [1:0]                bank_i,
    output logic [3:0][ROW_WIDTH-1:0] ra_o,
    output logic [COL_WIDTH-1:0]      ca_o,
    output logic [1:0]                ba_o,
    output logic [3:0]                row_active_o,
    output logic                      read_active_o,
    output logic                      write_active_o,
    output logic                      burst_stop_o,
    output logic [2:0]                burst_len_o,
    output logic                      burst_type_o,
    output logic [2:0]                cas_lat_o,
    output logic                      cmd_err_o
);

    cmd_e                 cmd_s;
    bank_state_e          bank_st_s [4];
    logic [3:0]           act_s, pre_s, tgt_s, pre_mask_s;
    logic                 all_idle_s, blocked_s;
    logic                 rd_go_s, wr_go_s, bst_go_s, mr_go_s, blk_go_s;
    logic [3:0]           blk_load_s;

    burst_state_e         burst_q, burst_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [3:0]           blk_q, blk_d;
    logic                 rd_act_q, rd_act_d, wr_act_q, wr_act_d;
    logic                 stop_q, stop_d, err_q, err_d;
    logic [COL_WIDTH-1:0] ca_q, ca_d;
    logic [1:0]           ba_q, ba_d;
    logic [2:0]           bl_q, bl_d, cl_q, cl_d;
    logic                 bt_q, bt_d;

    for (genvar g = 0; g < 4; g++) begin : g_bank
        ddr_bank_fsm #(
            .ROW_WIDTH (ROW_WIDTH),
            .T_RCD     (T_RCD),
            .T_RP      (T_RP)
        ) u_bank (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .act_i        (act_s[g]),
            .pre_i        (pre_s[g]),
            .row_i        (addr_i),
            .state_o      (bank_st_s[g]),
            .ra_o         (ra_o[g]),
            .row_active_o (row_active_o[g])
        );
    end

    assign cmd_s      = cs_n_i ? CMD_NOP : cmd_e'({1'b0, ras_n_i, cas_n_i, we_n_i});
    assign tgt_s      = 4'b0001 << bank_i;
    assign pre_mask_s = addr_i[10] ? 4'b1111 : tgt_s;
    assign blocked_s  = (blk_q != 4'd0);
    assign all_idle_s = (bank_st_s[0] == B_IDLE) && (bank_st_s[1] == B_IDLE) &&
                        (bank_st_s[2] == B_IDLE) && (bank_st_s[3] == B_IDLE);

    // Command legality; everything here looks at pre-edge state only.
    always_comb begin
        act_s      = 4'b0000;
        pre_s      = 4'b0000;
        rd_go_s    = 1'b0;
        wr_go_s    = 1'b0;
        bst_go_s   = 1'b0;
        mr_go_s    = 1'b0;
        blk_go_s   = 1'b0;
        blk_load_s = 4'd0;
        err_d      = 1'b0;
        if (!cke_i || (cmd_s == CMD_NOP)) begin
            err_d = 1'b0;
        end else if (blocked_s) begin
            err_d = 1'b1;
        end else begin
            case (cmd_s)
                CMD_ACT: begin
                    if (bank_st_s[bank_i] == B_IDLE) act_s = tgt_s;
                    else                             err_d = 1'b1;
                end
                CMD_RD, CMD_WR: begin
                    if ((bank_st_s[bank_i] == B_ACTIVE) && (burst_q == BU_IDLE) &&
                        (bl_beats(bl_q) != 4'd0)) begin
                        rd_go_s = (cmd_s == CMD_RD);
                        wr_go_s = (cmd_s == CMD_WR);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_BST: begin
                    if (burst_q == BU_BURST) bst_go_s = 1'b1;
                    else                     bst_go_s = 1'b0;
                end
                CMD_PRE: begin
                    // Non-ACTIVE banks in the mask simply ignore the request.
                    if ((burst_q == BU_BURST) && pre_mask_s[ba_q]) err_d = 1'b1;
                    else                                           pre_s = pre_mask_s;
                end
                CMD_REF, CMD_LMR: begin
                    if (all_idle_s && (burst_q == BU_IDLE)) begin
                        blk_go_s   = 1'b1;
                        blk_load_s = (cmd_s == CMD_LMR) ? 4'(T_MRD) : 4'(T_RFC);
                        mr_go_s    = (cmd_s == CMD_LMR) && (bank_i == 2'b00);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b0;
            endcase
        end
    end

    // Burst sequencing: BURST for BL/2 cycles (or until BST), then one GAP cycle.
    always_comb begin
        burst_d  = burst_q;
        bcnt_d   = bcnt_q;
        rd_act_d = rd_act_q;
        wr_act_d = wr_act_q;
        stop_d   = 1'b0;
        ca_d     = ca_q;
        ba_d     = ba_q;
        case (burst_q)
            BU_IDLE: begin
                if (rd_go_s || wr_go_s) begin
                    burst_d  = BU_BURST;
                    bcnt_d   = (bl_beats(bl_q) >> 1) - 4'd1;
                    rd_act_d = rd_go_s;
                    wr_act_d = wr_go_s;
                    ca_d     = addr_i[COL_WIDTH-1:0];
                    ba_d     = bank_i;
                end else begin
                    burst_d = BU_IDLE;
                end
            end
            BU_BURST: begin
                if (bst_go_s || (bcnt_q == 4'd0)) begin
                    burst_d  = BU_GAP;
                    rd_act_d = 1'b0;
                    wr_act_d = 1'b0;
                    stop_d   = bst_go_s;
                end else begin
                    bcnt_d = bcnt_q - 4'd1;
                end
            end
            BU_GAP:  burst_d = BU_IDLE;
            default: begin
                burst_d  = BU_IDLE;
                rd_act_d = 1'b0;
                wr_act_d = 1'b0;
            end
        endcase
    end

    // Mode register and the post-LMR/REF command block window.
    always_comb begin
        bl_d = bl_q;
        bt_d = bt_q;
        cl_d = cl_q;
        if (blk_go_s)       blk_d = blk_load_s;
        else if (blocked_s) blk_d = blk_q - 4'd1;
        else                blk_d = 4'd0;
        if (mr_go_s) begin
            bl_d = addr_i[2:0];
            bt_d = addr_i[3];
            cl_d = addr_i[6:4];
        end else begin
            bl_d = bl_q;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            burst_q  <= BU_IDLE;
            bcnt_q   <= 4'd0;
            blk_q    <= 4'd0;
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
            stop_q   <= 1'b0;
            err_q    <= 1'b0;
            ca_q     <= '0;
            ba_q     <= 2'd0;
            bl_q     <= MR_BL_RST;
            bt_q     <= MR_BT_RST;
            cl_q     <= MR_CL_RST;
        end else begin
            burst_q  <= burst_d;
            bcnt_q   <= bcnt_d;
            blk_q    <= blk_d;
            rd_act_q <= rd_act_d;
            wr_act_q <= wr_act_d;
            stop_q   <= stop_d;
            err_q    <= err_d;
            ca_q     <= ca_d;
            ba_q     <= ba_d;
            bl_q     <= bl_d;
            bt_q     <= bt_d;
            cl_q     <= cl_d;
        end
    end

    assign ca_o           = ca_q;
    assign ba_o           = ba_q;
    assign read_active_o  = rd_act_q;
    assign write_active_o = wr_act_q;
    assign burst_stop_o   = stop_q;
    assign burst_len_o    = bl_q;
    assign burst_type_o   = bt_q;
    assign cas_lat_o      = cl_q;
    assign cmd_err_o      = err_q;

endmodule

// File: tb/tb_ddr_cmd_ctrl.sv
// Directed and randomized bench for ddr_cmd_ctrl; the reference model tracks
// absolute edge numbers of accepted commands rather than FSM states.
module tb_ddr_cmd_ctrl;
    localparam int RW = 14, CW = 10;
    localparam int T_RCD = 2, T_RP = 2, T_MRD = 2, T_RFC = 8;
    localparam logic [3:0] P_LMR = 4'b0000, P_REF = 4'b0001, P_PRE = 4'b0010, P_ACT = 4'b0011;
    localparam logic [3:0] P_WR  = 4'b0100, P_RD  = 4'b0101, P_BST = 4'b0110, P_NOP = 4'b0111;

    logic clk = 1'b0, rst_n = 1'b1, cke = 1'b1;
    logic cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [RW-1:0] addr = '0;
    logic [1:0]    bank = 2'd0;
    logic [3:0][RW-1:0] ra;
    logic [CW-1:0] ca;
    logic [1:0]    ba;
    logic [3:0]    row_active;
    logic          read_active, write_active, burst_stop, burst_type, cmd_err;
    logic [2:0]    burst_len, cas_lat;

    ddr_cmd_ctrl #(
        .ROW_WIDTH (RW), .COL_WIDTH (CW), .T_RCD (T_RCD),
        .T_RP (T_RP), .T_MRD (T_MRD), .T_RFC (T_RFC)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n), .cke_i (cke),
        .cs_n_i (cs_n), .ras_n_i (ras_n), .cas_n_i (cas_n), .we_n_i (we_n),
        .addr_i (addr), .bank_i (bank),
        .ra_o (ra), .ca_o (ca), .ba_o (ba), .row_active_o (row_active),
        .read_active_o (read_active), .write_active_o (write_active),
        .burst_stop_o (burst_stop), .burst_len_o (burst_len),
        .burst_type_o (burst_type), .cas_lat_o (cas_lat), .cmd_err_o (cmd_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: t is the index of the most recent modelled edge.
    int  t = 0;
    bit  m_open [4];
    int  act_e [4];
    int  pre_e [4];
    int  bs, be, stop_e, blk_end;
    bit  m_rd, m_err;
    logic [3:0][RW-1:0] m_ra;
    logic [CW-1:0] m_ca;
    logic [1:0]    m_ba;
    logic [2:0]    m_bl, m_cl;
    logic          m_bt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic bit bank_ready(input int b);
        return m_open[b] && (t > act_e[b] + T_RCD);
    endfunction

    function automatic bit bank_idle(input int b);
        return !m_open[b] && (t > pre_e[b] + T_RP);
    endfunction

    function automatic bit burst_idle();
        return t > be + 1;
    endfunction

    function automatic bit in_burst();
        return (bs < t) && (t <= be);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 1'b0;
            act_e[b]  = -1000;
            pre_e[b]  = -1000;
        end
        bs = -1000; be = -1000; stop_e = -1000; blk_end = -1000;
        m_rd = 1'b0; m_err = 1'b0;
        m_ra = '0; m_ca = '0; m_ba = 2'd0;
        m_bl = 3'd1; m_bt = 1'b0; m_cl = 3'd2;
    endtask

    task automatic model_step();
        logic [3:0] pins;
        logic [3:0] mask;
        t++;
        m_err = 1'b0;
        pins  = {cs_n, ras_n, cas_n, we_n};
        if (cke && !cs_n && (pins != P_NOP)) begin
            if (t <= blk_end) begin
                m_err = 1'b1;
            end else begin
                case (pins)
                    P_ACT: begin
                        if (bank_idle(int'(bank))) begin
                            m_open[bank] = 1'b1; act_e[bank] = t; m_ra[bank] = addr;
                        end else m_err = 1'b1;
                    end
                    P_RD, P_WR: begin
                        if (bank_ready(int'(bank)) && burst_idle() && m_bl >= 3'd1 && m_bl <= 3'd3) begin
                            bs = t; be = t + (1 << (int'(m_bl) - 1)); stop_e = -1000;
                            m_rd = (pins == P_RD); m_ca = addr[CW-1:0]; m_ba = bank;
                        end else m_err = 1'b1;
                    end
                    P_BST: begin
                        if (in_burst()) begin be = t; stop_e = t; end
                    end
                    P_PRE: begin
                        mask = addr[10] ? 4'hF : (4'h1 << bank);
                        if (in_burst() && mask[m_ba]) m_err = 1'b1;
                        else begin
                            for (int b = 0; b < 4; b++) begin
                                if (mask[b] && bank_ready(b)) begin m_open[b] = 1'b0; pre_e[b] = t; end
                            end
                        end
                    end
                    P_REF, P_LMR: begin
                        if (bank_idle(0) && bank_idle(1) && bank_idle(2) && bank_idle(3) && burst_idle()) begin
                            blk_end = t + ((pins == P_LMR) ? T_MRD : T_RFC);
                            if (pins == P_LMR && bank == 2'd0) begin
                                m_bl = addr[2:0]; m_bt = addr[3]; m_cl = addr[6:4];
                            end
                        end else m_err = 1'b1;
                    end
                    default: m_err = 1'b0;
                endcase
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_ra_act;
        for (int b = 0; b < 4; b++) exp_ra_act[b] = m_open[b] && (t >= act_e[b] + T_RCD);
        chk("row_active",   64'(row_active),   64'(exp_ra_act));
        chk("read_active",  64'(read_active),  64'(m_rd && bs <= t && t < be));
        chk("write_active", 64'(write_active), 64'(!m_rd && bs <= t && t < be));
        chk("burst_stop",   64'(burst_stop),   64'(stop_e == t));
        chk("cmd_err",      64'(cmd_err),      64'(m_err));
        chk("ra",           64'(ra),           64'(m_ra));
        chk("ca",           64'(ca),           64'(m_ca));
        chk("ba",           64'(ba),           64'(m_ba));
        chk("mode",         64'({burst_len, burst_type, cas_lat}), 64'({m_bl, m_bt, m_cl}));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ra"},   64'(ra), 64'(0));
        chk({tag, "_ca"},   64'(ca), 64'(0));
        chk({tag, "_ba"},   64'(ba), 64'(0));
        chk({tag, "_ctl"},  64'({row_active, read_active, write_active, burst_stop, cmd_err}), 64'(0));
        chk({tag, "_mode"}, 64'({burst_len, burst_type, cas_lat}), 64'(7'b001_0_010));
    endtask

    task automatic cyc(input logic c, input logic [3:0] p, input logic [RW-1:0] a, input logic [1:0] b);
        @(negedge clk);
        cke = c; {cs_n, ras_n, cas_n, we_n} = p; addr = a; bank = b;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, P_NOP, '0, 2'd0);
    endtask

    initial begin
        int r;
        logic c;
        logic [3:0] p;
        logic [RW-1:0] a;
        logic [1:0] b;

        #2 rst_n = 1'b0;
        #1 check_reset("rst0");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b1, P_LMR, 14'h023, 2'd0);
        nops(T_MRD);
        chk("lmr_mode", 64'({burst_len, burst_type, cas_lat}), 64'(7'b011_0_010));
        cyc(1'b1, P_ACT, 14'h1A5, 2'd1);
        chk("act_ra1", 64'(ra[1]), 64'(14'h1A5));
        nops(1);
        chk("act_ra1_early", 64'(row_active[1]), 64'(0));
        nops(1);
        chk("act_ra1_up", 64'(row_active[1]), 64'(1));
        cyc(1'b1, P_RD, 14'h3F5, 2'd1);
        chk("rd_ca", 64'({ca, ba, read_active}), 64'({10'h3F5, 2'd1, 1'b1}));
        nops(6);

        cyc(1'b1, P_PRE, 14'h000, 2'd1);
        nops(T_RP);
        cyc(1'b1, P_LMR, 14'h002, 2'd0);
        nops(T_MRD);
        cyc(1'b1, P_ACT, 14'h0AA, 2'd1);
        nops(T_RCD);
        cyc(1'b1, P_WR, 14'h010, 2'd1);
        cyc(1'b1, P_BST, 14'h000, 2'd0);
        chk("bst_pulse", 64'({burst_stop, write_active, read_active}), 64'(3'b100));
        nops(1);
        cyc(1'b1, P_RD, 14'h011, 2'd2);
        chk("rd_idle_err", 64'(cmd_err), 64'(1));
        cyc(1'b1, P_ACT, 14'h055, 2'd1);
        chk("act_open_err", 64'(cmd_err), 64'(1));

        cyc(1'b1, P_ACT, 14'h100, 2'd0);
        cyc(1'b1, P_ACT, 14'h200, 2'd2);
        cyc(1'b1, P_ACT, 14'h300, 2'd3);
        nops(2);
        cyc(1'b1, P_PRE, 14'h400, 2'd0);
        chk("pre_all", 64'(row_active), 64'(0));
        cyc(1'b1, P_ACT, 14'h123, 2'd0);
        chk("act_trp_err", 64'(cmd_err), 64'(1));
        nops(1);
        cyc(1'b1, P_ACT, 14'h123, 2'd0);
        nops(T_RCD);
        cyc(1'b1, P_RD, 14'h005, 2'd0);

        #3 rst_n = 1'b0;
        {cs_n, ras_n, cas_n, we_n} = P_NOP;
        #1 check_reset("rst_mid");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, P_REF, 14'h000, 2'd0);
        cyc(1'b1, P_RD, 14'h001, 2'd0);
        chk("rd_trfc_err", 64'(cmd_err), 64'(1));
        nops(T_RFC);

        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            c = ($urandom_range(0, 19) != 0);
            a = RW'($urandom);
            b = 2'($urandom);
            if (r < 25)      p = P_NOP;
            else if (r < 29) p = {1'b1, 3'($urandom)};
            else if (r < 49) p = P_ACT;
            else if (r < 62) p = P_RD;
            else if (r < 75) p = P_WR;
            else if (r < 83) p = P_BST;
            else if (r < 92) begin
                p = P_PRE;
                a[10] = ($urandom_range(0, 3) == 0);
            end else if (r < 95) p = P_REF;
            else begin
                p = P_LMR;
                if ($urandom_range(0, 3) != 0) b = 2'd0;
                if ($urandom_range(0, 7) != 0) a[2:0] = 3'($urandom_range(1, 3));
            end
            cyc(c, p, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
